gene_attractor_scan: RTL and testbench

- Parametrised attractor analyser for an N-bit Boolean gene network. It supersedes the separate fixed-point and cycle checkers with a single block.
- Iterates the network from a given initial state and records every visited state in a history buffer. Classifies the attractor reached as fixed point, cycle or history overflow.
- Reports transient length, cycle length and the entry state of the attractor.
- The network update function stays external: the block drives the current state out, a combinational gene_net-style update instance returns the next state, and the same analyser serves any network width or rule set.

---
 rtl/gene_attractor_scan.sv | 151 +++++++++++++++
 tb/tb_gene_attractor_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gene_attractor_scan.sv
// Attractor analyser for an N-bit Boolean gene network with an external update function.
// Optional trace outputs are enabled by defining GENE_ATTR_TRACE_EN.
module gene_attractor_scan #(
    parameter int N          = 8,
    parameter int HIST_DEPTH = 16,
    localparam int CW        = $clog2(HIST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  init_val,
    output logic          ready,
    output logic [N-1:0]  net_x,
    input  logic [N-1:0]  net_fx,
    output logic          done,
    output logic [1:0]    attr_class,
    output logic [N-1:0]  attr_state,
    output logic [CW-1:0] cycle_len,
    output logic [CW-1:0] transient_len
`ifdef GENE_ATTR_TRACE_EN
    ,
    output logic          trace_valid,
    output logic [N-1:0]  trace_state
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  hist_q [HIST_DEPTH];
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  net_x_q;
    logic [N-1:0]  attr_state_q;
    logic [1:0]    attr_class_q;
    logic [CW-1:0] cycle_len_q;
    logic [CW-1:0] transient_len_q;

    logic          hit;
    logic [CW-1:0] hit_idx;
    logic [CW-1:0] cyc_d;
    logic          full;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [N-1:0]  wr_data;

    // Descending scan so the lowest matching valid index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = HIST_DEPTH; k > 0; k--) begin
            if ((CW'(k - 1) < cnt_q) && (hist_q[k-1] == net_fx)) begin
                hit     = 1'b1;
                hit_idx = CW'(k - 1);
            end
        end
    end

    assign cyc_d = cnt_q - hit_idx;
    assign full  = (cnt_q == CW'(HIST_DEPTH));

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = net_fx;
        if (state_q == S_IDLE && start) begin
            wr_en   = 1'b1;
            wr_data = init_val;
        end else if (state_q == S_RUN && !hit && !full) begin
            wr_en  = 1'b1;
            wr_idx = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            if (wr_en && (CW'(i) == wr_idx)) hist_q[i] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            net_x_q         <= '0;
            attr_class_q    <= '0;
            attr_state_q    <= '0;
            cycle_len_q     <= '0;
            transient_len_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        net_x_q         <= init_val;
                        cnt_q           <= CW'(1);
                        attr_class_q    <= '0;
                        attr_state_q    <= '0;
                        cycle_len_q     <= '0;
                        transient_len_q <= '0;
                        state_q         <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        transient_len_q <= hit_idx;
                        cycle_len_q     <= cyc_d;
                        attr_state_q    <= net_fx;
                        attr_class_q    <= (cyc_d == CW'(1)) ? 2'd1 : 2'd2;
                        state_q         <= S_DONE;
                    end else if (full) begin
                        attr_class_q    <= 2'd3;
                        transient_len_q <= CW'(HIST_DEPTH);
                        cycle_len_q     <= '0;
                        attr_state_q    <= net_fx;
                        state_q         <= S_DONE;
                    end else begin
                        net_x_q <= net_fx;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready         = (state_q == S_IDLE);
    assign done          = (state_q == S_DONE);
    assign net_x         = net_x_q;
    assign attr_class    = attr_class_q;
    assign attr_state    = attr_state_q;
    assign cycle_len     = cycle_len_q;
    assign transient_len = transient_len_q;

`ifdef GENE_ATTR_TRACE_EN
    logic         trace_valid_q;
    logic [N-1:0] trace_state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_state_q <= '0;
        end else begin
            trace_valid_q <= wr_en;
            trace_state_q <= wr_data;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_state = trace_state_q;
`endif

endmodule

// File: tb/tb_gene_attractor_scan.sv
// Scoreboard bench for gene_attractor_scan: a queue-based reference model predicts each scan.
// Trace outputs are checked when GENE_ATTR_TRACE_EN is defined.
module tb_gene_attractor_scan;

    localparam int N  = 8;
    localparam int HD = 16;
    localparam int CW = $clog2(HD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  init_val;
    logic          ready;
    logic [N-1:0]  net_x;
    logic [N-1:0]  net_fx;
    logic          done;
    logic [1:0]    attr_class;
    logic [N-1:0]  attr_state;
    logic [CW-1:0] cycle_len;
    logic [CW-1:0] transient_len;
`ifdef GENE_ATTR_TRACE_EN
    logic          trace_valid;
    logic [N-1:0]  trace_state;
`endif

    gene_attractor_scan #(.N(N), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst(rst), .start(start), .init_val(init_val), .ready(ready),
        .net_x(net_x), .net_fx(net_fx), .done(done), .attr_class(attr_class),
        .attr_state(attr_state), .cycle_len(cycle_len), .transient_len(transient_len)
`ifdef GENE_ATTR_TRACE_EN
        , .trace_valid(trace_valid), .trace_state(trace_state)
`endif
    );

    always #5 clk = ~clk;

    // External network: 0 rotl, 1 shift right, 2 increment, 3 random lookup table.
    int          mode = 0;
    logic [7:0]  lut [256];
    assign net_fx = (mode == 0) ? {net_x[6:0], net_x[7]} :
                    (mode == 1) ? (net_x >> 1) :
                    (mode == 2) ? (net_x + 8'd1) : lut[net_x];

    function automatic logic [7:0] f_ref(int m, logic [7:0] x);
        case (m)
            0:       return {x[6:0], x[7]};
            1:       return x >> 1;
            2:       return x + 8'd1;
            default: return lut[x];
        endcase
    endfunction

    typedef struct {
        logic [1:0] cls;
        logic [7:0] st;
        int         cyc;
        int         trans;
        int         lat;
        logic [7:0] last_x;
        longint     t_acc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] tq[$];
    exp_t       last_e;
    bit         have_last = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the orbit with a list of visited states until a repeat or the list is full.
    task automatic model(input int m, input logic [7:0] init, output exp_t e, output logic [7:0] vis[$]);
        logic [7:0] x, nx;
        int found;
        vis = {};
        vis.push_back(init);
        x = init;
        forever begin
            nx = f_ref(m, x);
            found = -1;
            foreach (vis[k]) if (found < 0 && vis[k] == nx) found = k;
            if (found >= 0) begin
                e.trans = found;
                e.cyc   = vis.size() - found;
                e.cls   = (e.cyc == 1) ? 2'd1 : 2'd2;
                e.st    = nx;
                e.lat   = e.trans + e.cyc;
                break;
            end
            if (vis.size() == HD) begin
                e.cls = 2'd3; e.st = nx; e.trans = HD; e.cyc = 0; e.lat = HD;
                break;
            end
            vis.push_back(nx);
            x = nx;
        end
        e.last_x = vis[vis.size()-1];
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (ready !== 1'b1) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic issue(input int m, input logic [7:0] init, input bit new_lut);
        exp_t e;
        logic [7:0] vis[$];
        wait_ready();
        if (have_last) begin
            chk("hold_class", attr_class, last_e.cls);
            chk("hold_state", attr_state, last_e.st);
            chk("hold_cycle", cycle_len, last_e.cyc);
            chk("hold_trans", transient_len, last_e.trans);
            chk("hold_net_x", net_x, last_e.last_x);
        end
        mode = m;
        if (new_lut) for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        model(m, init, e, vis);
        start    = 1'b1;
        init_val = init;
        @(posedge clk);
        e.t_acc = $time;
        sbq.push_back(e);
        foreach (vis[k]) tq.push_back(vis[k]);
        last_e    = e;
        have_last = 1;
        #1 start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done !== 1'b0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_latency", 32'($time - e.t_acc), 32'(e.lat * 10 + 5));
                chk("attr_class", attr_class, e.cls);
                chk("attr_state", attr_state, e.st);
                chk("cycle_len", cycle_len, e.cyc);
                chk("transient_len", transient_len, e.trans);
            end
        end
    end

`ifdef GENE_ATTR_TRACE_EN
    always @(negedge clk) begin
        if (trace_valid !== 1'b0) begin
            if (tq.size() == 0) chk("unexpected_trace", 32'(trace_valid), 0);
            else chk("trace_state", trace_state, tq.pop_front());
        end
    end
`endif

    initial begin
        rst = 1'b1; start = 1'b0; init_val = '0;
        for (int i = 0; i < 256; i++) lut[i] = 8'(i);
        #12;
        chk("rst_done", done, 0);
        chk("rst_class", attr_class, 0);
        chk("rst_state", attr_state, 0);
        chk("rst_cycle", cycle_len, 0);
        chk("rst_trans", transient_len, 0);
        chk("rst_net_x", net_x, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_ready", ready, 1);

        issue(0, 8'h00, 0);
        issue(0, 8'h55, 0);
        issue(0, 8'h01, 0);
        issue(1, 8'h80, 0);
        issue(2, 8'h10, 0);

        // Start pulses during RUN must be ignored.
        issue(0, 8'h01, 0);
        repeat (3) @(negedge clk);
        chk("busy_ready", ready, 0);
        start = 1'b1; init_val = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in the third RUN cycle abandons the scan.
        issue(0, 8'h01, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_done", done, 0);
        chk("arst_class", attr_class, 0);
        chk("arst_state", attr_state, 0);
        chk("arst_cycle", cycle_len, 0);
        chk("arst_trans", transient_len, 0);
        chk("arst_net_x", net_x, 0);
        sbq.delete();
        tq.delete();
        have_last = 0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(0, 8'h55, 0);

        repeat (30) begin
            int m;
            m = int'($urandom_range(0, 3));
            issue(m, 8'($urandom), m == 3);
        end

        begin
            int w = 0;
            while (sbq.size() != 0 && w < 300) begin
                @(negedge clk);
                w++;
            end
            chk("drain_scoreboard", sbq.size(), 0);
            repeat (2) @(negedge clk);
`ifdef GENE_ATTR_TRACE_EN
            chk("drain_trace", tq.size(), 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
